// File: rtl/ed25519_pkg.sv
// ed25519_pkg: shared constants, state encoding and helpers for the
// Ed25519 scalar multiply-add datapath.
//   ED_L      - group order L (253 bits)
//   L_W       - bit length of L
//   SWAP_MAX  - widest byte string byte_swap() handles
//   state_e   - controller states
//   byte_swap - reverse the low width/8 bytes of a value
//   clamp_scalar - Ed25519 scalar clamp on a little-endian integer
package ed25519_pkg;

  localparam int L_W = 253;
  localparam logic [L_W-1:0] ED_L =
    253'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

  localparam int SWAP_MAX = 512;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RED  = 3'd1,
    MUL  = 3'd2,
    ADD  = 3'd3,
    OUT  = 3'd4
  } state_e;

  // Byte 0 of the string (bits [7:0]) becomes the most significant byte of
  // the width-bit integer, and vice versa. Bits at and above width are zero.
  function automatic logic [SWAP_MAX-1:0] byte_swap(input logic [SWAP_MAX-1:0] value,
                                                    input int width);
    logic [SWAP_MAX-1:0] res;
    int nb;
    res = '0;
    nb  = width / 8;
    for (int i = 0; i < SWAP_MAX / 8; i++) begin
      if (i < nb) res[i*8 +: 8] = value[(nb-1-i)*8 +: 8];
    end
    return res;
  endfunction

  function automatic logic [255:0] clamp_scalar(input logic [255:0] value);
    logic [255:0] res;
    res        = value;
    res[2:0]   = 3'b000;
    res[255]   = 1'b0;
    res[254]   = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/modl_cond_sub.sv
// modl_cond_sub: combinational reduction of x < 3*MOD to x mod MOD using
// two compare-and-subtract stages.
//   x - operand, must be below 3*MOD
//   y - x mod MOD
module modl_cond_sub
  import ed25519_pkg::*;
#(
  parameter int W = L_W + 2,
  parameter logic [W-1:0] MOD = W'(ED_L)
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  logic [W-1:0] s1;

  always_comb begin
    s1 = (x >= MOD) ? (x - MOD) : x;
    y  = (s1 >= MOD) ? (s1 - MOD) : s1;
  end

endmodule

// File: rtl/scalar_muladd_modl.sv
// scalar_muladd_modl: S = (r + h*a) mod L (mode 0) or h*a mod L (mode 1)
// with a bit-serial interleaved datapath and fixed latency.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - operand handshake (ready only in IDLE)
//   in_mode             - 0: r + h*a, 1: h*a
//   in_r, in_h          - HASH_W-bit hash outputs, reduced mod L on entry
//   in_a                - A_W-bit scalar, optionally clamped
//   out_valid/out_ready - result handshake, out_s held until accepted
//   out_s               - result (< L), byte string when BYTE_SWAP=1
//   busy                - high outside IDLE
module scalar_muladd_modl
  import ed25519_pkg::*;
#(
  parameter int HASH_W    = 512,
  parameter int A_W       = 256,
  parameter bit CLAMP     = 1'b1,
  parameter bit BYTE_SWAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [HASH_W-1:0] in_r,
  input  logic [HASH_W-1:0] in_h,
  input  logic [A_W-1:0]    in_a,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [A_W-1:0]    out_s,
  output logic              busy
);

  localparam int ACC_W   = L_W + 2;
  localparam logic [ACC_W-1:0] L_EXT = ACC_W'(ED_L);
  localparam int CNT_MAX = (HASH_W > A_W) ? HASH_W : A_W;
  localparam int CNT_W   = $clog2(CNT_MAX);

  state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic [HASH_W-1:0] r_sh_q, r_sh_d;
  logic [HASH_W-1:0] h_sh_q, h_sh_d;
  logic [A_W-1:0]    a_sh_q, a_sh_d;
  logic [ACC_W-1:0]  acc_r_q, acc_r_d;
  logic [ACC_W-1:0]  acc_h_q, acc_h_d;
  logic [ACC_W-1:0]  acc_p_q, acc_p_d;
  logic [A_W-1:0]    out_s_q, out_s_d;
  logic              out_valid_q, out_valid_d;

  // Operand and result formatting.
  logic [SWAP_MAX-1:0] r_sw_full, h_sw_full, a_sw_full, s_sw_full;
  logic [HASH_W-1:0]   r_int, h_int;
  logic [A_W-1:0]      a_int, a_load, s_int, s_fmt;
  logic                unused_swap_hi;

  always_comb begin
    r_sw_full = byte_swap(SWAP_MAX'(in_r), HASH_W);
    h_sw_full = byte_swap(SWAP_MAX'(in_h), HASH_W);
    a_sw_full = byte_swap(SWAP_MAX'(in_a), A_W);
    r_int     = BYTE_SWAP ? r_sw_full[HASH_W-1:0] : in_r;
    h_int     = BYTE_SWAP ? h_sw_full[HASH_W-1:0] : in_h;
    a_int     = BYTE_SWAP ? a_sw_full[A_W-1:0] : in_a;
    a_load    = CLAMP ? A_W'(clamp_scalar(256'(a_int))) : a_int;
    // After ADD, acc_r holds the final residue (< L, so zero above L_W).
    s_int     = A_W'(acc_r_q);
    s_sw_full = byte_swap(SWAP_MAX'(s_int), A_W);
    s_fmt     = BYTE_SWAP ? s_sw_full[A_W-1:0] : s_int;
  end

  assign unused_swap_hi = ^{a_sw_full[SWAP_MAX-1:A_W], s_sw_full[SWAP_MAX-1:A_W]};

  // Modular step units. acc_h/acc_r < L, so 2*acc+bit < 2L+1 and
  // 2*acc_p + acc_h < 3L; both fit ACC_W bits and one unit covers each.
  logic [ACC_W-1:0] red_r_in, red_r_out;
  logic [ACC_W-1:0] red_h_in, red_h_out;
  logic [ACC_W-1:0] mul_in, mul_out;
  logic [ACC_W-1:0] add_in, add_out;

  always_comb begin
    red_r_in = {acc_r_q[ACC_W-2:0], r_sh_q[HASH_W-1]};
    red_h_in = {acc_h_q[ACC_W-2:0], h_sh_q[HASH_W-1]};
    mul_in   = {acc_p_q[ACC_W-2:0], 1'b0} + (a_sh_q[A_W-1] ? acc_h_q : '0);
    add_in   = acc_p_q + acc_r_q;
  end

  modl_cond_sub #(.W(ACC_W), .MOD(L_EXT)) u_red_r (.x(red_r_in), .y(red_r_out));
  modl_cond_sub #(.W(ACC_W), .MOD(L_EXT)) u_red_h (.x(red_h_in), .y(red_h_out));
  modl_cond_sub #(.W(ACC_W), .MOD(L_EXT)) u_mul   (.x(mul_in),   .y(mul_out));
  modl_cond_sub #(.W(ACC_W), .MOD(L_EXT)) u_add   (.x(add_in),   .y(add_out));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = RED;
      RED:  if (cnt_q == '0) state_d = MUL;
      MUL:  if (cnt_q == '0) state_d = ADD;
      ADD:  state_d = OUT;
      OUT:  if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
  end

  // Datapath next values.
  always_comb begin
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    r_sh_d      = r_sh_q;
    h_sh_d      = h_sh_q;
    a_sh_d      = a_sh_q;
    acc_r_d     = acc_r_q;
    acc_h_d     = acc_h_q;
    acc_p_d     = acc_p_q;
    out_s_d     = out_s_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d  = in_mode;
          r_sh_d  = r_int;
          h_sh_d  = h_int;
          a_sh_d  = a_load;
          acc_r_d = '0;
          acc_h_d = '0;
          acc_p_d = '0;
          cnt_d   = CNT_W'(HASH_W - 1);
        end
      end
      RED: begin
        acc_r_d = red_r_out;
        acc_h_d = red_h_out;
        r_sh_d  = r_sh_q << 1;
        h_sh_d  = h_sh_q << 1;
        cnt_d   = (cnt_q == '0) ? CNT_W'(A_W - 1) : cnt_q - CNT_W'(1);
      end
      MUL: begin
        acc_p_d = mul_out;
        a_sh_d  = a_sh_q << 1;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      ADD: begin
        // Final residue parks in acc_r; the formatting stage below picks it up.
        acc_r_d = mode_q ? acc_p_q : add_out;
      end
      OUT: begin
        // First OUT cycle registers the formatted result; later cycles
        // hold it until the consumer takes it.
        if (!out_valid_q) begin
          out_s_d     = s_fmt;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      r_sh_q      <= '0;
      h_sh_q      <= '0;
      a_sh_q      <= '0;
      acc_r_q     <= '0;
      acc_h_q     <= '0;
      acc_p_q     <= '0;
      out_s_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      r_sh_q      <= r_sh_d;
      h_sh_q      <= h_sh_d;
      a_sh_q      <= a_sh_d;
      acc_r_q     <= acc_r_d;
      acc_h_q     <= acc_h_d;
      acc_p_q     <= acc_p_d;
      out_s_q     <= out_s_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_s     = out_s_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_scalar_muladd_modl.sv
module tb_scalar_muladd_modl;

  localparam logic [511:0] L_C =
    512'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;
  localparam int LAT = 770;
  localparam int BOUND = 2000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_mode;
  logic [511:0] in_r, in_h;
  logic [255:0] in_a;

  logic         iv_p, ir_p, ov_p, or_p, bu_p;
  logic [255:0] os_p;
  logic         iv_d, ir_d, ov_d, or_d, bu_d;
  logic [255:0] os_d;

  scalar_muladd_modl #(.BYTE_SWAP(1'b0), .CLAMP(1'b0)) u_plain (
    .clk(clk), .rst(rst),
    .in_valid(iv_p), .in_ready(ir_p), .in_mode(in_mode),
    .in_r(in_r), .in_h(in_h), .in_a(in_a),
    .out_valid(ov_p), .out_ready(or_p), .out_s(os_p), .busy(bu_p)
  );

  scalar_muladd_modl u_def (
    .clk(clk), .rst(rst),
    .in_valid(iv_d), .in_ready(ir_d), .in_mode(in_mode),
    .in_r(in_r), .in_h(in_h), .in_a(in_a),
    .out_valid(ov_d), .out_ready(or_d), .out_s(os_d), .busy(bu_d)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Independent reference arithmetic.
  function automatic logic [511:0] swap512(input logic [511:0] v);
    logic [511:0] o;
    for (int i = 0; i < 64; i++) o[8*i +: 8] = v[8*(63-i) +: 8];
    return o;
  endfunction

  function automatic logic [255:0] swap256(input logic [255:0] v);
    logic [255:0] o;
    for (int i = 0; i < 32; i++) o[8*i +: 8] = v[8*(31-i) +: 8];
    return o;
  endfunction

  function automatic logic [255:0] clamp256(input logic [255:0] v);
    logic [255:0] o;
    o = v;
    o[2:0] = 3'b000;
    o[255] = 1'b0;
    o[254] = 1'b1;
    return o;
  endfunction

  function automatic logic [255:0] model(input bit mode, input logic [511:0] r,
                                         input logic [511:0] h, input logic [255:0] a);
    logic [767:0] lw, rr, hh, aa, p;
    lw = 768'(L_C);
    rr = 768'(r) % lw;
    hh = 768'(h) % lw;
    aa = 768'(a) % lw;
    p  = (hh * aa) % lw;
    if (!mode) p = (p + rr) % lw;
    return p[255:0];
  endfunction

  // Wait for ready, present operands for one accept edge, then scramble
  // the operand buses. Returns #1 after the accept edge.
  task automatic start_op(input bit sel, input bit mode, input logic [511:0] r,
                          input logic [511:0] h, input logic [255:0] a);
    int w;
    w = 0;
    @(negedge clk);
    while (!(sel ? ir_d : ir_p) && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    if (w >= BOUND) check("in_ready_timeout", 512'(0), 512'(1));
    in_mode = mode;
    in_r = r;
    in_h = h;
    in_a = a;
    if (sel) iv_d = 1'b1;
    else     iv_p = 1'b1;
    @(posedge clk);
    #1;
    iv_p = 1'b0;
    iv_d = 1'b0;
    in_r = ~r;
    in_h = ~h;
    in_a = ~a;
    in_mode = ~mode;
  endtask

  task automatic wait_result(input bit sel, output logic [255:0] s, output int lat);
    lat = 0;
    while (!(sel ? ov_d : ov_p) && lat < BOUND) begin
      @(posedge clk);
      #1;
      lat++;
    end
    s = sel ? os_d : os_p;
  endtask

  task automatic finish_op(input bit sel, input string name);
    if (sel) or_d = 1'b1;
    else     or_p = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_handoff_valid"}, 512'(sel ? ov_d : ov_p), 512'(0));
    check({name, "_handoff_ready"}, 512'(sel ? ir_d : ir_p), 512'(1));
    or_p = 1'b0;
    or_d = 1'b0;
  endtask

  typedef struct {
    bit           mode;
    logic [511:0] r;
    logic [511:0] h;
    logic [255:0] a;
    logic [255:0] s;
  } vec_t;

  localparam int NV = 9;
  vec_t vt[NV];

  initial begin
    logic [255:0] s, exp_s, a_b;
    logic [511:0] r_b, h_b, all1;
    int lat, bad;

    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] s, exp_s, a_b, hold_s;
    logic [511:0] r_b, h_b, all1, half;
    int lat, bad;

    all1 = '1;
    half = (L_C + 512'd1) >> 1;
    vt[0] = '{1'b0, 512'd5, 512'd3, 256'd7, 256'd26};
    vt[1] = '{1'b0, L_C + 512'd1, L_C + 512'd2, 256'(L_C - 512'd1), 256'(L_C - 512'd1)};
    vt[2] = '{1'b1, 512'd12345, 512'd2, half[255:0], 256'd1};
    vt[3] = '{1'b0, 512'd12345, 512'd2, half[255:0], 256'd12346};
    vt[4] = '{1'b0, 512'd0, 512'd0, 256'd0, 256'd0};
    vt[5] = '{1'b0, L_C - 512'd1, 512'd1, 256'd1, 256'd0};
    vt[6] = '{1'b1, 512'd99, L_C - 512'd1, 256'(L_C - 512'd1), 256'd1};
    vt[7] = '{1'b0, all1, 512'd0, 256'd0, model(1'b0, all1, 512'd0, 256'd0)};
    vt[8] = '{1'b1, 512'd0, 512'd1, all1[255:0], model(1'b1, 512'd0, 512'd1, all1[255:0])};

    rst = 1'b1;
    iv_p = 1'b0; iv_d = 1'b0; or_p = 1'b0; or_d = 1'b0;
    in_mode = 1'b0; in_r = '0; in_h = '0; in_a = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 512'(ov_p), 512'(0));
    check("reset_out_s", 512'(os_p), 512'(0));
    check("reset_busy", 512'(bu_p), 512'(0));
    check("reset_in_ready", 512'(ir_p), 512'(1));
    check("reset_def_busy", 512'(bu_d), 512'(0));
    rst = 1'b0;

    // Plain-integer vectors.
    for (int i = 0; i < NV; i++) begin
      start_op(1'b0, vt[i].mode, vt[i].r, vt[i].h, vt[i].a);
      wait_result(1'b0, s, lat);
      check($sformatf("vec%0d_s", i), 512'(s), 512'(vt[i].s));
      check($sformatf("vec%0d_latency", i), 512'(lat), 512'(LAT));
      finish_op(1'b0, $sformatf("vec%0d", i));
    end

    // Default configuration: byte strings in/out, clamped a.
    r_b = {8{64'h0123456789abcdef}};
    h_b = {8{64'hf0e1d2c3b4a59687}};
    a_b = 256'h9d61b19deffd5a60ba844af492ec2cc44449c5697b326919703bac031cae7f60;
    for (int k = 0; k < 3; k++) begin
      bit m;
      m = (k == 1);
      if (k == 2) begin
        r_b = '1;
        h_b = '1;
        a_b = '1;
      end
      exp_s = swap256(model(m, swap512(r_b), swap512(h_b), clamp256(swap256(a_b))));
      start_op(1'b1, m, r_b, h_b, a_b);
      wait_result(1'b1, s, lat);
      check($sformatf("def%0d_s", k), 512'(s), 512'(exp_s));
      check($sformatf("def%0d_latency", k), 512'(lat), 512'(LAT));
      finish_op(1'b1, $sformatf("def%0d", k));
    end

    // Output backpressure: result held, new operands ignored.
    start_op(1'b0, 1'b0, 512'd5, 512'd3, 256'd7);
    wait_result(1'b0, s, lat);
    check("bp_s", 512'(s), 512'd26);
    hold_s = s;
    bad = 0;
    iv_p = 1'b1;
    in_r = 512'd1; in_h = 512'd1; in_a = 256'd1; in_mode = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (os_p !== hold_s || ov_p !== 1'b1 || ir_p !== 1'b0 || bu_p !== 1'b1) bad++;
    end
    check("bp_hold_stable", 512'(bad), 512'(0));
    or_p = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 512'(ov_p), 512'(0));
    check("bp_release_ready", 512'(ir_p), 512'(1));
    check("bp_release_busy", 512'(bu_p), 512'(0));
    iv_p = 1'b0;
    or_p = 1'b0;

    // Reset mid-operation.
    start_op(1'b0, 1'b0, 512'd5, 512'd3, 256'd7);
    repeat (299) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 512'(ov_p), 512'(0));
    check("midrst_busy", 512'(bu_p), 512'(0));
    check("midrst_in_ready", 512'(ir_p), 512'(1));
    rst = 1'b0;
    start_op(1'b0, 1'b0, 512'd12345, 512'd2, half[255:0]);
    wait_result(1'b0, s, lat);
    check("post_rst_s", 512'(s), 512'd12346);
    check("post_rst_latency", 512'(lat), 512'(LAT));
    finish_op(1'b0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
